mac_tap_sequencer: RTL and testbench

//  Upstream controller for the fixed-point MAC (16b x 16b -> 32b accumulate).
//  - Accepts a valid/ready stream of (pixel, weight) tap pairs.
//  - Drives the MAC's a/b/c/ce/sclr so each window of TAPS pairs accumulates one dot product.
//  - Feeds the MAC's p back as the accumulate operand; c is forced to 0 on the first tap of each window.
//  - Presents each finished 32b sum on a one-entry valid/ready output towards the next CNN stage.

---
 rtl/cnn_pkg.sv | 12 +
 rtl/mac_out_slice.sv | 44 ++++
 rtl/mac_tap_sequencer.sv | 94 +++++++++
 tb/tb_mac_tap_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths and FSM encoding for the CNN MAC front end
package cnn_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_CAP = 1'b1
   } state_e;

endpackage

// File: rtl/mac_out_slice.sv
// rtl/mac_out_slice.sv - one-entry valid/ready result register
module mac_out_slice #(
   parameter int W = cnn_pkg::ACC_W
) (
   input  logic         clk,
   input  logic         sclr,
   input  logic         cap_valid,
   input  logic [W-1:0] cap_data,
   output logic         slot_free,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;

   // A capture may land in the same cycle the old entry drains.
   always_comb begin
      slot_free   = !out_valid_q || out_ready;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (cap_valid) begin
         out_valid_d = 1'b1;
         out_data_d  = cap_data;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/mac_tap_sequencer.sv
// rtl/mac_tap_sequencer.sv - feeds TAPS tap pairs per window into the MAC and captures each dot product
module mac_tap_sequencer #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int ACC_W  = cnn_pkg::ACC_W,
   parameter int TAPS   = 9
) (
   input  logic              clk,
   input  logic              sclr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pix,
   input  logic [DATA_W-1:0] in_wgt,
   output logic              mac_sclr,
   output logic              mac_ce,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic [ACC_W-1:0]  mac_c,
   input  logic [ACC_W-1:0]  mac_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data
);

   import cnn_pkg::*;

   localparam int               CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
   logic             mac_sclr_q, mac_sclr_d;
   logic             hs;
   logic             slot_free;
   logic             capture;

   assign in_ready = (state_q == ST_ACC);
   assign hs       = in_valid && in_ready;
   assign mac_ce   = hs;
   assign mac_a    = in_pix;
   assign mac_b    = in_wgt;
   // The first tap of a window must not inherit the previous window's sum.
   assign mac_c    = (tap_cnt_q == '0) ? '0 : mac_p;
   assign mac_sclr = mac_sclr_q;
   assign capture  = (state_q == ST_CAP) && slot_free;

   always_comb begin
      state_d    = state_q;
      tap_cnt_d  = tap_cnt_q;
      mac_sclr_d = sclr;
      case (state_q)
         ST_ACC: begin
            if (hs) begin
               if (tap_cnt_q == LAST_TAP) begin
                  tap_cnt_d = '0;
                  state_d   = ST_CAP;
               end else begin
                  tap_cnt_d = tap_cnt_q + 1'b1;
               end
            end
         end
         ST_CAP: begin
            if (slot_free) begin
               state_d = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      mac_sclr_q <= mac_sclr_d;
      if (sclr) begin
         state_q   <= ST_ACC;
         tap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tap_cnt_q <= tap_cnt_d;
      end
   end

   mac_out_slice #(
      .W (ACC_W)
   ) u_out (
      .clk       (clk),
      .sclr      (sclr),
      .cap_valid (capture),
      .cap_data  (mac_p),
      .slot_free (slot_free),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb/tb_mac_tap_sequencer.sv - scoreboard bench for mac_tap_sequencer with TAPS=9 and TAPS=1 instances
module tb_mac_tap_sequencer;

   localparam int TAPS = 9;

   logic        clk = 1'b0;
   logic        sclr = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_pix = '0;
   logic [15:0] in_wgt = '0;

   logic        in_ready, mac_sclr, mac_ce, out_valid;
   logic [15:0] mac_a, mac_b;
   logic [31:0] mac_c, out_data;
   logic [31:0] mac_p = '0;

   logic        in_ready1, mac_sclr1, mac_ce1, out_valid1;
   logic [15:0] mac_a1, mac_b1;
   logic [31:0] mac_c1, out_data1;
   logic [31:0] mac_p1 = '0;

   always #5 clk = ~clk;

   mac_tap_sequencer #(.DATA_W(16), .ACC_W(32), .TAPS(TAPS)) u_dut (
      .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
      .in_pix(in_pix), .in_wgt(in_wgt), .mac_sclr(mac_sclr), .mac_ce(mac_ce),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_p(mac_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   mac_tap_sequencer #(.DATA_W(16), .ACC_W(32), .TAPS(1)) u_dut1 (
      .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready1),
      .in_pix(in_pix), .in_wgt(in_wgt), .mac_sclr(mac_sclr1), .mac_ce(mac_ce1),
      .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_p(mac_p1),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
   );

   function automatic logic [31:0] tap_prod(input logic [15:0] p, input logic [15:0] w);
      int sp, sw;
      sp = int'($signed(p));
      sw = int'($signed(w));
      return 32'(sp * sw);
   endfunction

   // Behavioural MACs: registered p, cleared by mac_sclr, updated on ce.
   always @(posedge clk) begin
      if (mac_sclr)    mac_p <= '0;
      else if (mac_ce) mac_p <= mac_c + tap_prod(mac_a, mac_b);
      if (mac_sclr1)    mac_p1 <= '0;
      else if (mac_ce1) mac_p1 <= mac_c1 + tap_prod(mac_a1, mac_b1);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Controls written only by the stimulus process.
   int rst_phase = 0;
   bit thr_on = 0, t6_on = 0, stall_chk = 0, end_chk = 0;
   int tmo_cnt = 0;

   // Scoreboard state written only by the monitor.
   logic [31:0] exp_q[$];
   logic [31:0] exp1_q[$];
   logic [31:0] acc = '0;
   int k = 0, ce_cnt = 0, deliv = 0, last_del = 0, last_del1 = 0, tmo_seen = 0;
   bit have_last = 0, have_last1 = 0, thr_prev = 0, t6_prev = 0;
   logic rdy1_prev = 1'b0;

   always @(negedge clk) begin
      if (tmo_cnt != tmo_seen) begin
         vectors++;
         errors++;
         $display("FAIL timeout: got %0d expired waits expected 0", tmo_cnt);
         tmo_seen = tmo_cnt;
      end
      if (rst_phase == 1) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", out_data, 32'd0);
         chk("rst_mac_sclr", 32'(mac_sclr), 32'd1);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_valid_t1", 32'(out_valid1), 32'd0);
         chk("rst_mac_sclr_t1", 32'(mac_sclr1), 32'd1);
      end else if (rst_phase == 2) begin
         chk("rst_mac_sclr_release", 32'(mac_sclr), 32'd0);
      end
      if (stall_chk) begin
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_pending", 32'(exp_q.size()), 32'd2);
      end
      if (end_chk) begin
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
         chk("queue_empty_t1", 32'(exp1_q.size()), 32'd0);
         chk("results_delivered", 32'(deliv), 32'd14);
      end
      if (sclr) begin
         exp_q.delete();
         exp1_q.delete();
         acc = '0;
         k = 0;
         ce_cnt = 0;
         have_last = 0;
         have_last1 = 0;
      end else begin
         if (thr_on && !thr_prev) have_last = 0;
         if (t6_on && !t6_prev) have_last1 = 0;
         if (mac_ce) begin
            chk("mac_c", mac_c, (k == 0) ? 32'd0 : mac_p);
            ce_cnt++;
         end
         if (in_valid && in_ready) begin
            chk("mac_ab", {mac_a, mac_b}, {in_pix, in_wgt});
            acc += tap_prod(in_pix, in_wgt);
            k++;
            if (k == TAPS) begin
               exp_q.push_back(acc);
               chk("ce_per_window", 32'(ce_cnt), 32'(TAPS));
               acc = '0;
               k = 0;
               ce_cnt = 0;
            end
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL out_unexpected: got %h expected no result", out_data);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  deliv++;
                  if (thr_on && have_last) chk("window_period", 32'(cyc - last_del), 32'(TAPS + 1));
                  last_del = cyc;
                  have_last = 1;
               end
            end
         end
         if (in_valid && in_ready1) exp1_q.push_back(tap_prod(in_pix, in_wgt));
         if (out_valid1) begin
            if (exp1_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL out_unexpected_t1: got %h expected no result", out_data1);
            end else begin
               chk("out_data_t1", out_data1, exp1_q[0]);
               if (out_ready) begin
                  void'(exp1_q.pop_front());
                  if (t6_on && have_last1) chk("window_period_t1", 32'(cyc - last_del1), 32'd2);
                  last_del1 = cyc;
                  have_last1 = 1;
               end
            end
         end
         if (t6_on && t6_prev) chk("in_ready_toggle_t1", 32'(in_ready1), 32'(!rdy1_prev));
      end
      rdy1_prev = in_ready1;
      thr_prev = thr_on;
      t6_prev = t6_on;
   end

   task automatic do_reset();
      @(posedge clk); #1;
      in_valid = 1'b0;
      sclr = 1'b1;
      @(posedge clk); #1;
      sclr = 1'b0;
      rst_phase = 1;
      @(posedge clk); #1;
      rst_phase = 2;
      @(posedge clk); #1;
      rst_phase = 0;
   endtask

   task automatic feed(input logic [15:0] pix, input logic [15:0] wgt, input int vprob, input int n);
      int got = 0;
      int budget = 0;
      while (got < n) begin
         @(posedge clk); #1;
         in_pix = pix;
         in_wgt = wgt;
         in_valid = ($urandom_range(99) < 32'(vprob));
         @(negedge clk);
         if (in_valid && in_ready) got++;
         budget++;
         if (budget > 1000) begin
            tmo_cnt++;
            return;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   initial begin
      do_reset();
      out_ready = 1'b1;

      thr_on = 1;
      repeat (4) feed(16'h0100, 16'h0200, 100, TAPS);
      idle(4);
      thr_on = 0;

      feed(16'h0100, 16'h0100, 100, TAPS);
      feed(16'hFF00, 16'h0100, 100, TAPS);
      idle(4);

      repeat (3) feed(16'h0100, 16'h0200, 50, TAPS);
      idle(4);

      feed(16'h0100, 16'h0200, 100, TAPS);
      @(posedge clk); #1;
      out_ready = 1'b0;
      feed(16'h0100, 16'h0200, 100, TAPS);
      idle(18);
      stall_chk = 1;
      @(posedge clk); #1;
      stall_chk = 0;
      out_ready = 1'b1;
      idle(6);

      feed(16'h0100, 16'h0200, 100, 4);
      do_reset();
      feed(16'h0100, 16'h0200, 100, TAPS);
      idle(4);

      @(posedge clk); #1;
      t6_on = 1;
      in_pix = 16'h0300;
      in_wgt = 16'h0100;
      in_valid = 1'b1;
      repeat (19) begin
         @(posedge clk); #1;
      end
      t6_on = 0;
      idle(4);

      end_chk = 1;
      @(posedge clk); #1;
      end_chk = 0;
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
